// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO.
// Holds the per-cycle operation decode used by the top-level count update.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    FIFO_IDLE,
    FIFO_WR,
    FIFO_RD,
    FIFO_RW
  } fifo_op_e;

  function automatic int clog2_min1(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(int depth);
    return clog2_min1(depth);
  endfunction

  // One extra wrap bit distinguishes full from empty when addresses match.
  function automatic int ptr_w(int depth);
    return clog2_min1(depth) + 1;
  endfunction

  function automatic fifo_op_e op_decode(logic wr_acc, logic rd_acc);
    case ({wr_acc, rd_acc})
      2'b10:   return FIFO_WR;
      2'b01:   return FIFO_RD;
      2'b11:   return FIFO_RW;
      default: return FIFO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// DATA_W x DEPTH flop array: synchronous write port, asynchronous read port.
module fifo_storage
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [addr_w(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [addr_w(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale
  // contents are never observed and the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LVL);
  localparam logic [PW-1:0] ONE  = PW'(1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!(AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_bad_lvl
    $fatal(1, "sync_fifo_param: thresholds need AE_LVL < AF_LVL <= DEPTH");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $fatal(1, "sync_fifo_param: DATA_W must be in 1..32");
  end

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic              rd_acc, wr_acc;
  logic              empty_nxt, full_nxt;
  fifo_op_e          op;
  logic [DATA_W-1:0] mem_rd_data;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_acc     = rd_en & ~empty;
    wr_acc     = wr_en & (~full | rd_acc);
    op         = op_decode(wr_acc, rd_acc);
    wr_ptr_nxt = wr_acc ? wr_ptr + ONE : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + ONE : rd_ptr;
    count_nxt  = count;
    case (op)
      FIFO_WR: count_nxt = count + ONE;
      FIFO_RD: count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // A new error in the clearing cycle still sets the flag.
      overflow     <= (overflow  & ~clr_err) | (wr_en & ~wr_acc);
      underflow    <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
    end
  end

  fifo_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is exposed directly; rd_en only advances the read pointer.
  assign rd_data  = mem_rd_data;
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rd_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=4, AF_LVL=3, AE_LVL=1).
// Read checks adapt to SYNC_FIFO_FWFT_EN when that macro is defined.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]    count;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] model[$];
  int            msb_toggles = 0;
  logic          prev_wmsb = 1'b0;
  logic          prev_rmsb = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  // Pointer wrap-bit activity, sampled away from the active edge.
  always @(negedge clk) begin
    if (dut.wr_ptr[2] != prev_wmsb) msb_toggles = msb_toggles + 1;
    if (dut.rd_ptr[2] != prev_rmsb) msb_toggles = msb_toggles + 1;
    prev_wmsb = dut.wr_ptr[2];
    prev_rmsb = dut.rd_ptr[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt);
    chk({tag, "_count"}, 32'(count), 32'(cnt));
    chk({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, "_full"},  32'(full),  32'(cnt == DEPTH));
    chk({tag, "_af"},    32'(almost_full),  32'(cnt >= AF));
    chk({tag, "_ae"},    32'(almost_empty), 32'(cnt <= AE));
  endtask

  // Pops the head of the model and checks it in the mode-appropriate cycle.
  task automatic pop_check(input string tag);
    logic [DW-1:0] exp;
    exp   = model.pop_front();
    rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk({tag, "_data"},  32'(rd_data),  32'(exp));
    cycle();
`else
    cycle();
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk({tag, "_data"},  32'(rd_data),  32'(exp));
`endif
    rd_en = 1'b0;
  endtask

  initial begin
    int written, guard, toggles_before;
    logic [DW-1:0] exp;
    logic did_rd;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    cycle();
    cycle();
    chk_state("reset", 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_udf", 32'(underflow), 0);
    chk("reset_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset_data", 32'(rd_data), 0);
`endif
    rst = 1'b0;

    // Fill with 0xA1..0xA4
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hA1 + i);
      model.push_back(wr_data);
      cycle();
      chk_state($sformatf("fill%0d", i), i + 1);
    end
    wr_en = 1'b0;

    // Overflow: 0xFF while full is dropped, flag is sticky until clr_err
    wr_en = 1'b1; wr_data = 8'hFF;
    cycle();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk_state("ovf", 4);
    cycle();
    chk("ovf_sticky", 32'(overflow), 1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Simultaneous read and write while full
    wr_en = 1'b1; wr_data = 8'hB1;
    model.push_back(8'hB1);
    pop_check("rw_full");
    wr_en = 1'b0;
    chk_state("rw_full", 4);
    chk("rw_full_ovf", 32'(overflow), 0);

    // Drain: A2, A3, A4, B1
    for (int i = 0; i < DEPTH; i++) begin
      pop_check($sformatf("drain%0d", i));
      chk_state($sformatf("drain%0d", i), 3 - i);
    end
    cycle();
    chk("idle_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("idle_hold", 32'(rd_data), 32'(8'hB1));
`endif

    // Underflow on empty
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 1);
    chk("udf_valid", 32'(rd_valid), 0);
    chk_state("udf", 0);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("udf_clr", 32'(underflow), 0);

    // Read+write on empty: write accepted, read rejected
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hC3;
    cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    model.push_back(8'hC3);
    chk("erw_udf", 32'(underflow), 1);
    chk_state("erw", 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("erw_valid", 32'(rd_valid), 1);
    chk("erw_data", 32'(rd_data), 32'(8'hC3));
`else
    chk("erw_valid", 32'(rd_valid), 0);
`endif
    pop_check("erw_pop");

    // Clear and new error in the same cycle: set wins
    clr_err = 1'b1; rd_en = 1'b1;
    cycle();
    clr_err = 1'b0; rd_en = 1'b0;
    chk("clr_vs_set", 32'(underflow), 1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_final", 32'(underflow), 0);

    // Wrap-around: 20 words with interleaved reads
    written = 0;
    guard = 0;
    toggles_before = msb_toggles;
    while (written < 20 && guard < 60) begin
      did_rd  = (model.size() > 0) && (guard % 3 != 0);
      rd_en   = did_rd;
      wr_en   = (model.size() < DEPTH) || did_rd;
      wr_data = 8'(8'h10 + written);
      exp     = '0;
      if (did_rd) begin
        exp = model.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        chk($sformatf("wrap%0d_data", guard), 32'(rd_data), 32'(exp));
`endif
      end
      if (wr_en) begin
        model.push_back(wr_data);
        written++;
      end
      cycle();
`ifndef SYNC_FIFO_FWFT_EN
      if (did_rd) begin
        chk($sformatf("wrap%0d_valid", guard), 32'(rd_valid), 1);
        chk($sformatf("wrap%0d_data", guard), 32'(rd_data), 32'(exp));
      end
`endif
      chk($sformatf("wrap%0d_count", guard), 32'(count), 32'(model.size()));
      guard++;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk("wrap_written", 32'(written), 20);
    while (model.size() > 0) pop_check("wrap_drain");
    chk_state("wrap_end", 0);
    cycle();
    chk("wrap_msb_toggles", 32'(msb_toggles - toggles_before >= 4), 1);
    chk("wrap_ovf", 32'(overflow), 0);
    chk("wrap_udf", 32'(underflow), 0);

    // Reset mid-operation with two stored words
    wr_en = 1'b1;
    wr_data = 8'h61; cycle();
    wr_data = 8'h62; cycle();
    chk_state("pre_rst", 2);
    rst = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    cycle();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    model.delete();
    chk_state("mid_rst", 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_udf", 32'(underflow), 0);
    chk("mid_rst_valid", 32'(rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_data", 32'(rd_data), 0);
`endif

    wr_en = 1'b1; wr_data = 8'h5A;
    cycle();
    wr_en = 1'b0;
    model.push_back(8'h5A);
    chk_state("post_rst_wr", 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_fwft_valid", 32'(rd_valid), 1);
    chk("post_rst_fwft_data", 32'(rd_data), 32'(8'h5A));
`endif
    pop_check("post_rst_rd");
    chk_state("final", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
